vga_color_unit: RTL and testbench

- Registered, programmable pixel-colour stage for the VGA text-mode display path. It sits between the glyph-bitmap lookup (which supplies current_bit for the cell being scanned) and the VGA DAC outputs.
- Generalises the fixed column-zone colouring into ZONES programmable column zones with per-zone foreground colours, a default foreground and a background colour, all writable over a config port.
- Adds a frame-counted blinking cursor that inverts the glyph bit.

---
 rtl/vga_color_unit.sv | 169 ++++++++++++++++
 tb/tb_vga_color_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_color_unit.sv
// Registered pixel-colour stage: programmable column zones, default fg, bg, blinking cursor.
// Latency: exactly one clock from pix_valid/current_bit/col/row to vga_r/g/b and out_valid.
// Backpressure: none; a pixel is accepted every cycle. Config writes take effect at the edge.
//
// Ports:
//   clk, clrn                    pixel clock, synchronous active-low reset
//   pix_valid, current_bit       active-video qualifier and glyph bit for this pixel
//   col, row                     character cell of this pixel
//   frame_start                  one-cycle pulse per frame, drives the cursor blink counter
//   cursor_en/col/row            cursor enable and position
//   cfg_we/addr/wdata            config port: limits, zone colours, default fg, bg
//   vga_r/g/b, out_valid         registered DAC outputs and delayed pixel qualifier
module vga_color_unit #(
    parameter int ZONES        = 2,
    parameter int COL_W        = 8,
    parameter int ROW_W        = 5,
    parameter int CH_W         = 8,
    parameter int BLINK_FRAMES = 30,
    parameter int ADDR_W       = $clog2(2*ZONES+2)
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              pix_valid,
    input  logic              current_bit,
    input  logic [COL_W-1:0]  col,
    input  logic [ROW_W-1:0]  row,
    input  logic              frame_start,
    input  logic              cursor_en,
    input  logic [COL_W-1:0]  cursor_col,
    input  logic [ROW_W-1:0]  cursor_row,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [3*CH_W-1:0] cfg_wdata,
    output logic [CH_W-1:0]   vga_r,
    output logic [CH_W-1:0]   vga_g,
    output logic [CH_W-1:0]   vga_b,
    output logic              out_valid
);

    localparam int CW    = 3*CH_W;
    localparam int CNT_W = $clog2(BLINK_FRAMES+1);

    // "F0" channel value generalised: 4'hF in the top nibble, zeros below.
    localparam logic [CH_W-1:0] HI = CH_W'(4'hF) << (CH_W-4);
    localparam logic [CH_W-1:0] LO = '0;

    localparam logic [CW-1:0] RST_COLOUR0 = {LO, HI, HI};  // cyan
    localparam logic [CW-1:0] RST_COLOUR1 = {HI, HI, LO};  // yellow
    localparam logic [CW-1:0] RST_DFG     = {HI, HI, HI};
    localparam logic [CW-1:0] RST_BG      = '0;

    localparam logic [ADDR_W-1:0] ADDR_DFG = ADDR_W'(2*ZONES);
    localparam logic [ADDR_W-1:0] ADDR_BG  = ADDR_W'(2*ZONES+1);

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    logic [COL_W-1:0] r_limit  [ZONES];
    logic [CW-1:0]    r_colour [ZONES];
    logic [CW-1:0]    r_default_fg;
    logic [CW-1:0]    r_bg;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            for (int i = 0; i < ZONES; i++) begin
                if (i == 0) begin
                    r_limit[i]  <= COL_W'(8);
                    r_colour[i] <= RST_COLOUR0;
                end else if (i == 1) begin
                    r_limit[i]  <= COL_W'(10);
                    r_colour[i] <= RST_COLOUR1;
                end else begin
                    r_limit[i]  <= '0;
                    r_colour[i] <= '0;
                end
            end
            r_default_fg <= RST_DFG;
            r_bg         <= RST_BG;
        end else if (cfg_we) begin
            for (int i = 0; i < ZONES; i++) begin
                if (cfg_addr == ADDR_W'(i))
                    r_limit[i] <= cfg_wdata[COL_W-1:0];
                if (cfg_addr == ADDR_W'(ZONES+i))
                    r_colour[i] <= cfg_wdata;
            end
            if (cfg_addr == ADDR_DFG)
                r_default_fg <= cfg_wdata;
            if (cfg_addr == ADDR_BG)
                r_bg <= cfg_wdata;
            // Addresses beyond ADDR_BG match nothing above and are dropped.
        end
    end

    // ------------------------------------------------------------------
    // Cursor blink: phase toggles every BLINK_FRAMES frame_start pulses
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_blink_cnt;
    logic             r_blink_phase;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (r_blink_cnt == CNT_W'(BLINK_FRAMES-1)) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Cursor is visible during phase 0 and shows as an inverted glyph bit.
    logic w_cursor_hit;
    logic w_eff_bit;

    assign w_cursor_hit = cursor_en && (col == cursor_col) && (row == cursor_row)
                          && !r_blink_phase;
    assign w_eff_bit    = current_bit ^ w_cursor_hit;

    // ------------------------------------------------------------------
    // Foreground zone select: lowest-index zone with col < limit wins.
    // A zero limit can never satisfy the unsigned compare, so it disables
    // the zone without a separate enable bit.
    // ------------------------------------------------------------------
    logic [CW-1:0] w_fg;
    logic          w_zone_found;

    always_comb begin
        w_fg         = r_default_fg;
        w_zone_found = 1'b0;
        for (int i = 0; i < ZONES; i++) begin
            if (!w_zone_found && (col < r_limit[i])) begin
                w_fg         = r_colour[i];
                w_zone_found = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic [CW-1:0] w_pix_next;
    logic [CW-1:0] r_pix;
    logic          r_out_valid;

    always_comb begin
        w_pix_next = '0;
        if (pix_valid)
            w_pix_next = w_eff_bit ? w_fg : r_bg;
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_pix       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_pix       <= w_pix_next;
            r_out_valid <= pix_valid;
        end
    end

    assign vga_r     = r_pix[CW-1     -: CH_W];
    assign vga_g     = r_pix[2*CH_W-1 -: CH_W];
    assign vga_b     = r_pix[CH_W-1   -: CH_W];
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_vga_color_unit.sv
// Bench for vga_color_unit: directed steps plus a random phase, checked against
// a frame-count based reference model of the colour rules.
// One step = drive inputs, one rising edge, compare registered outputs.
module tb_vga_color_unit;

    localparam int ZONES = 2;
    localparam int BF    = 30;

    logic        clk = 1'b0;
    logic        clrn;
    logic        pix_valid;
    logic        current_bit;
    logic [7:0]  col;
    logic [4:0]  row;
    logic        frame_start;
    logic        cursor_en;
    logic [7:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [23:0] cfg_wdata;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        out_valid;

    vga_color_unit #(
        .ZONES(ZONES), .COL_W(8), .ROW_W(5), .CH_W(8), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .clrn(clrn), .pix_valid(pix_valid), .current_bit(current_bit),
        .col(col), .row(row), .frame_start(frame_start), .cursor_en(cursor_en),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .vga_r(vga_r), .vga_g(vga_g),
        .vga_b(vga_b), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_lim [ZONES];
    logic [23:0] m_col [ZONES];
    logic [23:0] m_dfg, m_bg;
    int          m_frames;

    task automatic model_reset();
        m_lim[0] = 8;  m_col[0] = 24'h00F0F0;
        m_lim[1] = 10; m_col[1] = 24'hF0F000;
        m_dfg = 24'hF0F0F0; m_bg = 24'h000000;
        m_frames = 0;
    endtask

    function automatic logic [23:0] model_pix(input logic pv, input logic b,
                                              input int c, input int r);
        logic [23:0] fg;
        logic        blink_on, hit, eff;
        bit          found;
        fg = m_dfg;
        found = 0;
        for (int i = 0; i < ZONES; i++)
            if (!found && c < m_lim[i]) begin
                fg = m_col[i];
                found = 1;
            end
        blink_on = ((m_frames / BF) % 2) == 0;
        hit = cursor_en && c == int'(cursor_col) && r == int'(cursor_row) && blink_on;
        eff = b ^ hit;
        if (!pv) return 24'h0;
        return eff ? fg : m_bg;
    endfunction

    task automatic step(input logic rn, input logic pv, input logic b,
                        input int c, input int r, input logic fs,
                        input logic we, input int a, input logic [23:0] wd,
                        input string tag);
        logic [23:0] exp_pix, got_pix;
        logic        exp_vld;
        clrn = rn; pix_valid = pv; current_bit = b;
        col = 8'(c); row = 5'(r); frame_start = fs;
        cfg_we = we; cfg_addr = 3'(a); cfg_wdata = wd;
        exp_pix = rn ? model_pix(pv, b, c, r) : 24'h0;
        exp_vld = rn ? pv : 1'b0;
        @(posedge clk); #1;
        got_pix = {vga_r, vga_g, vga_b};
        checks++;
        assert (got_pix === exp_pix) else begin
            errors++;
            $error("FAIL %s rgb: got %06h expected %06h", tag, got_pix, exp_pix);
        end
        checks++;
        assert (out_valid === exp_vld) else begin
            errors++;
            $error("FAIL %s out_valid: got %0b expected %0b", tag, out_valid, exp_vld);
        end
        // Apply state changes that took effect at this edge
        if (!rn) begin
            model_reset();
        end else begin
            if (we) begin
                if (a < ZONES)            m_lim[a] = int'(wd[7:0]);
                else if (a < 2*ZONES)     m_col[a-ZONES] = wd;
                else if (a == 2*ZONES)    m_dfg = wd;
                else if (a == 2*ZONES+1)  m_bg = wd;
            end
            if (fs) m_frames++;
        end
    endtask

    task automatic pix(input logic b, input int c, input int r, input string tag);
        step(1, 1, b, c, r, 0, 0, 0, 24'h0, tag);
    endtask

    initial begin
        cursor_en = 0; cursor_col = 0; cursor_row = 0;
        model_reset();

        // Reset, including a frame_start that must be ignored
        step(0, 1, 1, 3, 0, 1, 0, 0, 24'h0, "reset0");
        step(0, 0, 0, 0, 0, 0, 1, 0, 24'h000001, "reset1");

        // Default zones
        pix(1, 3,  0, "zone0");
        pix(1, 9,  0, "zone1");
        pix(1, 12, 0, "deflt");
        pix(0, 3,  0, "bg_def");
        step(1, 0, 1, 3, 0, 0, 0, 0, 24'h0, "novalid");
        pix(1, 7,  0, "zone0_edge");
        pix(1, 8,  0, "zone1_edge");
        pix(1, 10, 0, "deflt_edge");

        // Write colour[0] concurrently with a pixel: old value seen first
        step(1, 1, 1, 2, 0, 0, 1, ZONES+0, 24'h123456, "wr_same");
        pix(1, 2, 0, "wr_next");

        // Disable zone 0, program bg, then out-of-range writes
        step(1, 0, 0, 0, 0, 0, 1, 0, 24'h000000, "wr_lim0");
        pix(1, 3, 0, "lim0_fall");
        step(1, 0, 0, 0, 0, 0, 1, 2*ZONES+1, 24'h202020, "wr_bg");
        pix(0, 3, 0, "bg_new");
        step(1, 0, 0, 0, 0, 0, 1, 6, 24'hABCDEF, "wr_oob6");
        step(1, 0, 0, 0, 0, 0, 1, 7, 24'h00FEDC, "wr_oob7");
        pix(1, 3,  0, "oob_z1");
        pix(1, 12, 0, "oob_df");
        pix(0, 12, 0, "oob_bg");
        step(1, 0, 0, 0, 0, 0, 1, 2*ZONES, 24'h0A0B0C, "wr_dfg");
        pix(1, 200, 0, "dfg_new");

        // Cursor blink
        step(0, 0, 0, 0, 0, 0, 0, 0, 24'h0, "reset2");
        cursor_en = 1; cursor_col = 5; cursor_row = 2;
        pix(0, 5, 2, "cur_on");
        pix(0, 6, 2, "cur_other");
        pix(1, 5, 2, "cur_on_b1");
        for (int k = 0; k < BF; k++)
            step(1, 0, 0, 0, 0, 1, 0, 0, 24'h0, "frames_a");
        pix(0, 5, 2, "cur_off");
        pix(1, 5, 2, "cur_off_b1");
        for (int k = 0; k < BF; k++)
            step(1, k == BF-1, 0, 5, 2, 1, 0, 0, 24'h0, "frames_b");
        pix(0, 5, 2, "cur_back");
        pix(0, 6, 2, "cur_other2");

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic        rn, pv, b, fs, we;
            int          c, r, a;
            logic [23:0] wd;
            rn = ($urandom_range(0, 99) != 0);
            pv = ($urandom_range(0, 3) != 0);
            b  = 1'($urandom);
            c  = $urandom_range(0, 31);
            r  = $urandom_range(0, 3);
            fs = ($urandom_range(0, 2) == 0);
            we = ($urandom_range(0, 4) == 0);
            a  = $urandom_range(0, 7);
            wd = 24'($urandom);
            if (a < ZONES) wd[7:0] = 8'($urandom_range(0, 32));
            if (n % 97 == 0) begin
                cursor_en  = 1'($urandom);
                cursor_col = 8'($urandom_range(0, 31));
                cursor_row = 5'($urandom_range(0, 3));
            end
            step(rn, pv, b, c, r, fs, we, a, wd, "rand");
        end

        // Reset mid-stream after custom config restores defaults
        step(1, 0, 0, 0, 0, 0, 1, ZONES+1, 24'h777777, "wr_c1");
        step(1, 0, 0, 0, 0, 0, 1, 0, 24'h000002, "wr_l0");
        step(0, 1, 1, 3, 0, 0, 0, 0, 24'h0, "reset_mid");
        cursor_en = 0;
        pix(1, 3,  0, "post_z0");
        pix(1, 9,  0, "post_z1");
        pix(1, 12, 0, "post_df");
        pix(0, 12, 0, "post_bg");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
